// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: four-requester round-robin arbiter.
// A registered 2-bit owner index drives a one-hot grant. The owner keeps
// the grant until it pulses done or drops its request. Priority then
// rotates past the released owner, and one dead IDLE cycle separates
// consecutive grants.
// Optional feature macro: DECODER_RR_ARBITER_TIMEOUT_EN. When it is defined,
// a grant that lasts HOLD_MAX cycles is force-released and timeout pulses.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] last_q;
    logic [1:0] gnt_idx_q;
    logic [3:0] gnt_q;
    logic       busy_q;

    // Candidate indices in priority order: last+1, last+2, last+3, last+4 (mod 4).
    logic [1:0] cand   [4];
    logic [3:0] hit;
    logic [3:0] gnt_d;
    logic [1:0] pick_idx_d;
    logic       pick_valid_d;
    logic       release_d;
    logic       expire_d;
    logic       timeout_d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = last_q + 2'(gi + 1);
            assign hit[gi]  = req_i[cand[gi]];
        end
    endgenerate

    // The first requesting candidate in rotated order wins.
    always_comb begin
        pick_valid_d = |hit;
        pick_idx_d   = cand[0];
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                pick_idx_d = cand[i];
            end
        end
    end

    // Decode the winning index to the one-hot grant that will be registered.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign gnt_d[gi] = (pick_idx_d == 2'(gi));
        end
    endgenerate

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    localparam int HOLD_CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [HOLD_CW-1:0] hold_q;
    logic               timeout_q;

    // The counter reads HOLD_MAX-1 on the edge that would start cycle HOLD_MAX+1.
    assign expire_d  = (hold_q == HOLD_CW'(HOLD_MAX - 1));
    // A timeout is flagged only when nothing else would release on that edge.
    assign timeout_d = expire_d & ~done_i & req_i[gnt_idx_q];

    // Hold counter: cleared when a grant starts, counts every held cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                hold_q <= '0;
            end else if (release_d) begin
                hold_q    <= '0;
                timeout_q <= timeout_d;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expire_d  = 1'b0;
    assign timeout_d = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // The owner releases on done, on dropping its request, or on expiry.
    assign release_d = done_i | ~req_i[gnt_idx_q] | expire_d;

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= 2'b11;
            gnt_idx_q <= 2'b00;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_d) begin
                        state_q   <= GRANT;
                        gnt_idx_q <= pick_idx_d;
                        gnt_q     <= gnt_d;
                        busy_q    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        last_q  <= gnt_idx_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter. Expected output vectors are queued
// when the stimulus is driven and then checked against the outputs.
module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [3:0] g, input logic [1:0] i,
                        input logic b, input logic t);
        exp_t e;
        e.gnt  = g;
        e.idx  = i;
        e.busy = b;
        e.to   = t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pops the oldest expectation and compares it with the present outputs.
    task automatic check_now();
        exp_t  e;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        vectors++;
        assert (gnt === e.gnt) else begin
            miscompares++;
            $display("FAIL %s gnt: observed %b expected %b", tag, gnt, e.gnt);
            $error("%s gnt", tag);
        end
        vectors++;
        assert (busy === e.busy) else begin
            miscompares++;
            $display("FAIL %s busy: observed %b expected %b", tag, busy, e.busy);
            $error("%s busy", tag);
        end
        vectors++;
        assert (timeout === e.to) else begin
            miscompares++;
            $display("FAIL %s timeout: observed %b expected %b", tag, timeout, e.to);
            $error("%s timeout", tag);
        end
        vectors++;
        assert (gnt_idx === e.idx) else begin
            miscompares++;
            $display("FAIL %s gnt_idx: observed %0d expected %0d", tag, gnt_idx, e.idx);
            $error("%s gnt_idx", tag);
        end
        $display("%-16s req=%b done=%b -> gnt=%b idx=%0d busy=%b timeout=%b",
                 tag, req, done, gnt, gnt_idx, busy, timeout);
    endtask

    // Queue the expectation, clock once, then sample 1 time unit later.
    task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] i,
                       input logic b, input logic t);
        push(tag, g, i, b, t);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_now();
        rst = 1'b0;

        // Full rotation with every agent requesting.
        req = 4'b1111;
        cyc("rr_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1; cyc("rr_r0", 4'b0000, 2'd0, 1'b0, 1'b0); done = 1'b0;
        cyc("rr_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1; cyc("rr_r1", 4'b0000, 2'd1, 1'b0, 1'b0); done = 1'b0;
        cyc("rr_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1; cyc("rr_r2", 4'b0000, 2'd2, 1'b0, 1'b0); done = 1'b0;
        cyc("rr_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1; cyc("rr_r3", 4'b0000, 2'd3, 1'b0, 1'b0); done = 1'b0;
        cyc("rr_g0_again", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1; cyc("rr_r0_again", 4'b0000, 2'd0, 1'b0, 1'b0); done = 1'b0;

        // Set last to 1, then req 0101 must skip 1 and take 2, then wrap to 0.
        req = 4'b0010;
        cyc("set_last1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1; cyc("set_last1_rel", 4'b0000, 2'd1, 1'b0, 1'b0); done = 1'b0;
        req = 4'b0101;
        cyc("skip_to2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1; cyc("skip_rel", 4'b0000, 2'd2, 1'b0, 1'b0); done = 1'b0;
        cyc("wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1; cyc("wrap_rel", 4'b0000, 2'd0, 1'b0, 1'b0); done = 1'b0;

        // Owner 3 drops its request while agent 0 waits.
        req = 4'b1000;
        cyc("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0001;
        cyc("drop3", 4'b0000, 2'd3, 1'b0, 1'b0);
        cyc("pend0", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Other requests arriving during a grant are ignored.
        req = 4'b1111;
        cyc("hold_others", 4'b0001, 2'd0, 1'b1, 1'b0);
        // done and owner-req drop on the same edge form one release.
        req = 4'b0000; done = 1'b1;
        cyc("done_and_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        cyc("stay_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant to agent 1.
        req = 4'b0010;
        cyc("pre_rst_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        push("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1010;
        cyc("post_rst_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1; cyc("post_rst_rel", 4'b0000, 2'd1, 1'b0, 1'b0); done = 1'b0;

        // Long hold by agent 2 (last is 1, so 2 wins).
        req = 4'b0100;
        cyc("hold_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
        cyc("hold_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("hold_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("hold_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("expire", 4'b0000, 2'd2, 1'b0, 1'b1);
        cyc("regrant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("regrant_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("regrant_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc("regrant_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
        // done on the expiry edge is a normal release with no timeout pulse.
        done = 1'b1;
        cyc("done_at_expiry", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;
`else
        for (int k = 0; k < 6; k++) begin
            cyc("no_expire", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        done = 1'b1;
        cyc("long_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;
`endif

        // done in IDLE with no requests changes nothing.
        req  = 4'b0000;
        done = 1'b1;
        cyc("idle_done_a", 4'b0000, 2'd2, 1'b0, 1'b0);
        cyc("idle_done_b", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;
        // Last owner was 2, so with 1111 the next grant goes to 3.
        req = 4'b1111;
        cyc("after_idle_g3", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Four-requester round-robin arbiter that shares one downstream resource and drives its select with a one-hot grant. The grant vector comes from a registered 2-bit owner index, decoded 2-to-4. It sits between requesting agents and the shared datapath: it holds a grant until the owner releases it, then rotates priority so no requester starves.

## Interface
- `HOLD_MAX`, default 16: maximum grant length in cycles. Used only when the timeout feature is compiled in. Legal range 2..256.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request per agent; bit i is agent i. Held high while the agent wants the resource.
- `done`  input  1  one-cycle release pulse from the current owner. Ignored when not in GRANT.
- `gnt`  output  4  one-hot grant. All zero when no owner. Registered.
- `gnt_idx`  output  2  binary index of the current owner. Valid while `busy`=1. Registered.
- `busy`  output  1  high while a grant is held. Registered.
- `timeout`  output  1  one-cycle pulse when a grant is force-released. Registered.

## Operation
- State machine with two states.
  - IDLE: no grant outstanding.
  - GRANT: one owner holds the resource.
- Round-robin pointer `last`, 2 bits: the index of the most recently granted agent.
- Arbitration, in IDLE with any `req` bit high:
  - Search indices `last`+1, `last`+2, `last`+3, `last`+4, all mod 4.
  - The first index with `req` high becomes the owner.
  - Load `gnt_idx` with that index, set `gnt` = 1<<idx, set `busy`=1, go to GRANT.
  - In IDLE with `req`=0: stay in IDLE, outputs unchanged at zero.
- Release, in GRANT, triggered by any one of:
  - (a) `done`=1;
  - (b) `req[gnt_idx]`=0;
  - (c) timeout, when compiled in.
- On release:
  - `gnt`=0 and `busy`=0; `gnt_idx` holds its last value.
  - `last` := owner.
  - Go to IDLE.
- IDLE always lasts at least one cycle after a release. There is no back-to-back grant; this gives the datapath a dead cycle for select switching.
- Requests from non-owners during GRANT have no effect until the next IDLE.
- `gnt` is always one-hot or zero and always equals the 2-to-4 decode of `gnt_idx` gated by `busy`.
- Reset values: state=IDLE, `gnt`=4'b0000, `gnt_idx`=2'b00, `busy`=0, `timeout`=0, `last`=2'b11. After reset, agent 0 has first priority.

## Timing
- Grant latency: `req` high sampled at edge k → `gnt`/`busy` high after edge k. Zero wait cycles from IDLE.
- Release: `done` sampled at edge m → `gnt`=0 after edge m. The earliest next grant is after edge m+1.
- `done` and an owner-`req` drop on the same edge count as a single release.
- `done` arriving with other `req` bits high releases normally. The next owner is chosen in the following IDLE cycle using the updated `last`.
- Reset asserted mid-grant clears `gnt`, `busy` and `timeout` immediately, without waiting for a clock edge. `last` returns to 3.
- Reset deassertion is synchronized externally. The first arbitration happens on the first edge with `rst`=0.

## Configuration
- Macro: `DECODER_RR_ARBITER_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the owner has held `gnt` for `HOLD_MAX` cycles without releasing, the arbiter force-releases exactly as in Operation.
  - `timeout` pulses high for one cycle, in the first IDLE cycle.
  - `done` on the same edge as expiry counts as a normal release, and `timeout` stays 0.
- Undefined:
  - No counter is built, `HOLD_MAX` is unused, and `timeout` is tied to 0.
  - A grant lasts until `done` or owner `req` drop.

## Test plan
- Reset then `req`=4'b1111 held, `done` pulsed one cycle after each grant → grant sequence 0,1,2,3,0, with one IDLE cycle (`gnt`=0) between grants.
- `last`=1, `req`=4'b0101 → `gnt`=4'b0100 and `gnt_idx`=2 (skips 1, wraps correctly). Next round with the same `req` → `gnt`=4'b0001.
- Owner 3 drops `req[3]` without `done` → `gnt`=0 the next cycle, `last`=3. A pending `req[0]` is granted one cycle later.
- `rst` pulsed while `gnt`=4'b0010 → `gnt`=0 and `busy`=0 without a clock edge. After release, `req`=4'b1010 grants agent 1 first, since `last` was reset to 3.
- Timeout compiled in, `HOLD_MAX`=4, `req[2]` held with no `done` → `gnt`=4'b0100 for exactly 4 cycles, then `timeout`=1 for one cycle, then `req[2]` is re-granted after the IDLE cycle.
- `done` pulsed in IDLE with `req`=0 → no state change, all outputs stay 0.
